uart_mmio: RTL and testbench

Memory-mapped UART peripheral on the CPU data bus, directly downstream of `cpu_logic`. It decodes the CPU's `address`/`Wr_en` store traffic to a fixed I/O window and buffers written bytes in a TX FIFO. It serialises them 8N1 on `uart_tx` and returns status/RX data on the read path that feeds `memory_out`.

---
 rtl/uart_mmio_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_mmio.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS
// bit positions, transmitter/receiver state encodings and the baud divisor
// helper.
package uart_mmio_pkg;

  // Register offsets inside the I/O window
  localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;

  // STATUS register bit positions
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_OVF      = 4;
  localparam int ST_RX_OVR   = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Clock cycles per bit, rounded to nearest
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pointers wrap naturally; a push
// while full and a pop while empty are ignored. Full is based on the count
// at the edge, so a push into a full FIFO is dropped even if a pop happens
// in the same cycle.
module sync_fifo
  import uart_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART. DATA (+0) pushes into the TX FIFO / returns the
// received byte; STATUS (+4) reports FIFO/transmitter/receiver flags and
// clears sticky error flags on write. The receiver is only built when the
// macro UART_MMIO_RX_EN is defined; otherwise all RX state reads as zero.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        Wr_en,
  input  logic        rd_en,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int DIV  = baud_div(CLK_HZ, BAUD);
  localparam int CW   = $clog2(DIV);
  localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

  // Address decode
  logic data_sel_s, stat_sel_s, push_s, stat_wr_s;
  assign data_sel_s = (address == BASE_ADDR + OFS_DATA);
  assign stat_sel_s = (address == BASE_ADDR + OFS_STATUS);
  assign hit        = data_sel_s | stat_sel_s;
  assign push_s     = Wr_en & data_sel_s;
  assign stat_wr_s  = Wr_en & stat_sel_s;

  // TX FIFO
  logic           pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]     fifo_dout_s;
  logic [FCW-1:0] fifo_count_s;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (wr_data[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Sticky overflow: dropped store sets it, STATUS write with bit4 clears it
  logic ovf_r;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (push_s && fifo_full_s) begin
      ovf_r <= 1'b1;
    end else if (stat_wr_s && wr_data[ST_OVF]) begin
      ovf_r <= 1'b0;
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_e      tx_state_r, tx_state_s;
  logic [CW-1:0]  tx_cnt_r;
  logic [2:0]     tx_idx_r;
  logic [7:0]     tx_shift_r;
  logic           tx_bit_end_s, tx_line_s;

  assign tx_bit_end_s = (tx_cnt_r == BIT_LAST);

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_r <= TX_IDLE;
    end else begin
      tx_state_r <= tx_state_s;
    end
  end

  // TX next-state: each bit lasts DIV cycles, STOP chains straight into START
  always_comb begin
    tx_state_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (!fifo_empty_s) tx_state_s = TX_START;
        else               tx_state_s = TX_IDLE;
      end
      TX_START: begin
        if (tx_bit_end_s) tx_state_s = TX_DATA;
        else              tx_state_s = TX_START;
      end
      TX_DATA: begin
        if (tx_bit_end_s && (tx_idx_r == 3'd7)) tx_state_s = TX_STOP;
        else                                   tx_state_s = TX_DATA;
      end
      TX_STOP: begin
        if (!tx_bit_end_s)      tx_state_s = TX_STOP;
        else if (!fifo_empty_s) tx_state_s = TX_START;
        else                    tx_state_s = TX_IDLE;
      end
      default: tx_state_s = TX_IDLE;
    endcase
  end

  // TX outputs: FIFO pop strobe and next serial line level
  always_comb begin
    pop_s     = 1'b0;
    tx_line_s = 1'b1;
    case (tx_state_r)
      TX_IDLE: begin
        pop_s     = ~fifo_empty_s;
        tx_line_s = 1'b1;
      end
      TX_START: begin
        pop_s     = 1'b0;
        tx_line_s = 1'b0;
      end
      TX_DATA: begin
        pop_s     = 1'b0;
        tx_line_s = tx_shift_r[0];
      end
      TX_STOP: begin
        pop_s     = tx_bit_end_s & ~fifo_empty_s;
        tx_line_s = 1'b1;
      end
      default: begin
        pop_s     = 1'b0;
        tx_line_s = 1'b1;
      end
    endcase
  end

  // TX datapath: bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_r   <= '0;
      tx_idx_r   <= 3'd0;
      tx_shift_r <= 8'd0;
    end else if (pop_s) begin
      tx_cnt_r   <= '0;
      tx_idx_r   <= 3'd0;
      tx_shift_r <= fifo_dout_s;
    end else if (tx_state_r != TX_IDLE) begin
      if (tx_bit_end_s) begin
        tx_cnt_r <= '0;
        if (tx_state_r == TX_DATA) begin
          tx_shift_r <= {1'b0, tx_shift_r[7:1]};
          tx_idx_r   <= tx_idx_r + 3'd1;
        end
      end else begin
        tx_cnt_r <= tx_cnt_r + CW'(1);
      end
    end
  end

  // Registered serial output; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_tx <= 1'b1;
    end else begin
      uart_tx <= tx_line_s;
    end
  end

  // ---------------- Receiver ----------------
  logic       rx_valid_s, rx_ovr_s;
  logic [7:0] rx_byte_s;

`ifdef UART_MMIO_RX_EN
  localparam logic [CW-1:0] BIT_HALF = CW'(DIV / 2);

  rx_state_e     rx_state_r, rx_state_s;
  logic          rx_meta_r, rx_sync_r, rx_prev_r;
  logic [CW-1:0] rx_cnt_r;
  logic [2:0]    rx_idx_r;
  logic [7:0]    rx_shift_r, rx_byte_r;
  logic          rx_valid_r, rx_ovr_r;
  logic          rx_mid_s, rx_end_s, rx_done_s;

  assign rx_mid_s = (rx_cnt_r == BIT_HALF);
  assign rx_end_s = (rx_cnt_r == BIT_LAST);

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_r <= RX_IDLE;
    end else begin
      rx_state_r <= rx_state_s;
    end
  end

  // RX next-state: glitchy starts (high at mid-bit) fall back to idle
  always_comb begin
    rx_state_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_prev_r && !rx_sync_r) rx_state_s = RX_START;
        else                         rx_state_s = RX_IDLE;
      end
      RX_START: begin
        if (!rx_mid_s)     rx_state_s = RX_START;
        else if (rx_sync_r) rx_state_s = RX_IDLE;
        else               rx_state_s = RX_DATA;
      end
      RX_DATA: begin
        if (rx_end_s && (rx_idx_r == 3'd7)) rx_state_s = RX_STOP;
        else                               rx_state_s = RX_DATA;
      end
      RX_STOP: begin
        if (rx_end_s) rx_state_s = RX_IDLE;
        else          rx_state_s = RX_STOP;
      end
      default: rx_state_s = RX_IDLE;
    endcase
  end

  // RX output: a byte is delivered only when its stop sample is high
  always_comb begin
    rx_done_s = 1'b0;
    case (rx_state_r)
      RX_STOP: rx_done_s = rx_end_s & rx_sync_r;
      default: rx_done_s = 1'b0;
    endcase
  end

  // RX datapath: sample timer, bit index and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt_r   <= '0;
      rx_idx_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      case (rx_state_r)
        RX_START: begin
          rx_idx_r <= 3'd0;
          if (rx_mid_s) rx_cnt_r <= '0;
          else          rx_cnt_r <= rx_cnt_r + CW'(1);
        end
        RX_DATA: begin
          if (rx_end_s) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_idx_r   <= rx_idx_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_end_s) rx_cnt_r <= '0;
          else          rx_cnt_r <= rx_cnt_r + CW'(1);
        end
        default: rx_cnt_r <= '0;
      endcase
    end
  end

  // RX holding register and flags; a completing byte beats a clearing read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_ovr_r   <= 1'b0;
    end else begin
      if (rx_done_s) begin
        rx_byte_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rd_en && data_sel_s) begin
        rx_valid_r <= 1'b0;
      end
      if (rx_done_s && rx_valid_r) begin
        rx_ovr_r <= 1'b1;
      end else if (stat_wr_s && wr_data[ST_RX_OVR]) begin
        rx_ovr_r <= 1'b0;
      end
    end
  end

  assign rx_valid_s = rx_valid_r;
  assign rx_ovr_s   = rx_ovr_r;
  assign rx_byte_s  = rx_byte_r;
`else
  logic unused_rx_s;
  assign unused_rx_s = ^{uart_rx, rd_en, wr_data[ST_RX_OVR]};
  assign rx_valid_s  = 1'b0;
  assign rx_ovr_s    = 1'b0;
  assign rx_byte_s   = 8'd0;
`endif

  logic unused_common_s;
  assign unused_common_s = ^{wr_data[31:8], fifo_count_s};

  // Read mux: purely combinational from address and registered state
  logic [31:0] status_s;
  assign status_s = {26'd0, rx_ovr_s, ovf_r, rx_valid_s,
                     (tx_state_r != TX_IDLE), fifo_empty_s, fifo_full_s};

  always_comb begin
    rd_data = 32'd0;
    if (stat_sel_s) begin
      rd_data = status_s;
    end else if (data_sel_s) begin
      rd_data = {24'd0, rx_byte_s};
    end else begin
      rd_data = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio. A line monitor decodes uart_tx into
// bytes and start-bit cycles; each test task compares them against what an
// 8N1 UART with an 8-entry FIFO must produce. RX checks run only when
// UART_MMIO_RX_EN is defined.
module tb_uart_mmio;

  localparam int          DIV   = 434;
  localparam int          FRAME = 10 * DIV;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] STAT  = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic        Wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        uart_rx = 1'b1;
  logic        hit;
  logic [31:0] rd_data;
  logic        uart_tx;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  int         start_q[$];
  logic [7:0] byte_q[$];
  logic       stop_q[$];

  uart_mmio #(
    .CLK_HZ(50_000_000), .BAUD(115200), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .wr_data(wr_data),
    .Wr_en(Wr_en), .rd_en(rd_en), .hit(hit), .rd_data(rd_data),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Line decoder: start-bit cycle, 8 mid-bit samples LSB first, stop sample
  initial begin : line_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        stop_q.push_back(uart_tx);
        byte_q.push_back(b);
      end
    end
  end

  // Called just after a negedge; the store is taken at the next posedge
  task automatic store(input logic [31:0] a, input logic [31:0] d, output int e);
    address = a; wr_data = d; Wr_en = 1'b1;
    @(negedge clk);
    e = cyc;
    Wr_en = 1'b0; address = 32'd0; wr_data = 32'd0;
  endtask

  task automatic read(input logic [31:0] a, output logic [31:0] d, output logic h);
    address = a;
    #1;
    d = rd_data; h = hit;
  endtask

  task automatic clear_mon();
    start_q.delete(); byte_q.delete(); stop_q.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (byte_q.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    n_tests++;
    if (byte_q.size() !== n) begin
      n_fail++;
      $display("FAIL frame_count: got %0d frames, expected %0d", byte_q.size(), n);
    end
  endtask

  // Compare decoded frames with the expected byte list, first start cycle, and
  // back-to-back spacing of exactly one frame
  task automatic check_frames(input string name, input logic [7:0] exp_q[$], input int first_start);
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      n_tests++;
      if (byte_q[i] !== exp_q[i] || stop_q[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_byte[%0d]: got 0x%02h stop=%b, expected 0x%02h stop=1",
                 name, i, byte_q[i], stop_q[i], exp_q[i]);
      end
      n_tests++;
      if (start_q[i] !== first_start + i * FRAME) begin
        n_fail++;
        $display("FAIL %s_start[%0d]: got cycle %0d, expected %0d",
                 name, i, start_q[i], first_start + i * FRAME);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic h;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", uart_tx); end
    read(STAT, d, h);
    n_tests++;
    if (d !== 32'h2 || h !== 1'b1) begin n_fail++; $display("FAIL reset_status: got 0x%08h hit=%b, expected 0x00000002 hit=1", d, h); end
    read(32'h0, d, h);
    n_tests++;
    if (d !== 32'h0 || h !== 1'b0) begin n_fail++; $display("FAIL reset_outside: got 0x%08h hit=%b, expected 0 hit=0", d, h); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    read(BASE, d, h);
    n_tests++;
    if (d !== 32'h0 || h !== 1'b1) begin n_fail++; $display("FAIL reset_data: got 0x%08h hit=%b, expected 0 hit=1", d, h); end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$]; logic [31:0] d; logic h; int e;
    clear_mon();
    exp_q.push_back(8'h55);
    store(BASE, 32'h0000_0055, e);
    wait_bytes(1, FRAME + 50);
    check_frames("single", exp_q, e + 2);
    while (cyc < e + FRAME) @(negedge clk);
    read(STAT, d, h);
    n_tests++;
    if (d[2] !== 1'b1) begin n_fail++; $display("FAIL single_busy_end: got %b, expected 1", d[2]); end
    @(negedge clk);
    read(STAT, d, h);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL single_idle_status: got 0x%08h, expected 0x00000002", d); end
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [7:0] exp_q[$]; logic [31:0] d, exp_st; logic h, exp_ovf;
    int e, e0, acc, pops, occ;
    clear_mon();
    acc = 0; exp_ovf = 1'b0;
    for (int k = 0; k < 10; k++) begin
      store(BASE, 32'h41 + k, e);
      if (k == 0) e0 = e;
      // pops happen at e0+1, then one frame apart, only for accepted bytes
      pops = 0;
      for (int j = 0; j < acc; j++) if (e0 + 1 + j * FRAME < e) pops++;
      occ = acc - pops;
      if (occ < DEPTH) begin exp_q.push_back(8'(8'h41 + k)); acc++; end
      else exp_ovf = 1'b1;
      pops = 0;
      for (int j = 0; j < acc; j++) if (e0 + 1 + j * FRAME <= e) pops++;
      occ = acc - pops;
      exp_st = {27'd0, exp_ovf, 1'b0, 1'b1, (occ == 0), (occ == DEPTH)};
      if (k >= 8) begin
        read(STAT, d, h);
        n_tests++;
        if (d !== exp_st) begin n_fail++; $display("FAIL burst_status[%0d]: got 0x%08h, expected 0x%08h", k, d, exp_st); end
      end
    end
    store(STAT, 32'h0000_0010, e);
    read(STAT, d, h);
    n_tests++;
    if (d[4] !== 1'b0 || d[0] !== (occ == DEPTH)) begin
      n_fail++; $display("FAIL burst_ovf_clear: got 0x%08h, expected bit4=0 bit0=%0d", d, occ == DEPTH);
    end
    wait_bytes(exp_q.size(), exp_q.size() * FRAME + 100);
    check_frames("burst", exp_q, e0 + 2);
    repeat (DIV) @(negedge clk);
    read(STAT, d, h);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL burst_end_status: got 0x%08h, expected 0x00000002", d); end
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [31:0] addrs[3]; logic [31:0] d, a; logic h; int e;
    clear_mon();
    do a = $urandom(); while (a == BASE || a == STAT);
    addrs[0] = 32'hFFFF_0008; addrs[1] = 32'h0000_0000; addrs[2] = a;
    for (int i = 0; i < 3; i++) begin
      store(addrs[i], $urandom(), e);
      read(addrs[i], d, h);
      n_tests++;
      if (h !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL decode_miss[%0d]: got hit=%b data=0x%08h, expected 0 0", i, h, d); end
    end
    read(STAT, d, h);
    n_tests++;
    if (d !== 32'h2 || h !== 1'b1) begin n_fail++; $display("FAIL decode_status: got 0x%08h hit=%b, expected 0x00000002 hit=1", d, h); end
    repeat (2 * DIV) @(negedge clk);
    n_tests++;
    if (start_q.size() !== 0) begin n_fail++; $display("FAIL decode_no_frame: got %0d frames, expected 0", start_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$]; logic [7:0] b; int n, e, e0;
    clear_mon();
    n = $urandom_range(2, 3);
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom());
      exp_q.push_back(b);
      store(BASE, {24'($urandom()), b}, e);
      if (k == 0) e0 = e;
    end
    wait_bytes(n, n * FRAME + 100);
    check_frames("random", exp_q, e0 + 2);
    repeat (DIV) @(negedge clk);
  endtask

`ifdef UART_MMIO_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0; repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (DIV) @(negedge clk); end
    uart_rx = stop_bit; repeat (DIV) @(negedge clk);
    uart_rx = 1'b1; repeat (8) @(negedge clk);
  endtask

  task automatic test_rx();
    logic [31:0] d; logic h; logic [7:0] b2; int e;
    send_rx(8'hA3, 1'b1);
    read(STAT, d, h);
    n_tests++;
    if (d[3] !== 1'b1) begin n_fail++; $display("FAIL rx_valid_set: got %b, expected 1", d[3]); end
    address = BASE; rd_en = 1'b1; #1;
    n_tests++;
    if (rd_data !== 32'hA3) begin n_fail++; $display("FAIL rx_data: got 0x%08h, expected 0x000000a3", rd_data); end
    @(negedge clk); rd_en = 1'b0;
    read(STAT, d, h);
    n_tests++;
    if (d[3] !== 1'b0) begin n_fail++; $display("FAIL rx_valid_clear: got %b, expected 0", d[3]); end
    b2 = 8'($urandom());
    send_rx(8'h3C, 1'b1);
    send_rx(b2, 1'b1);
    read(STAT, d, h);
    n_tests++;
    if (d[5] !== 1'b1 || d[3] !== 1'b1) begin n_fail++; $display("FAIL rx_overrun: got 0x%08h, expected bits5,3 set", d); end
    read(BASE, d, h);
    n_tests++;
    if (d !== {24'd0, b2}) begin n_fail++; $display("FAIL rx_overwrite: got 0x%08h, expected 0x%08h", d, {24'd0, b2}); end
    store(STAT, 32'h0000_0020, e);
    address = BASE; rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    send_rx(8'h5A, 1'b0);
    read(STAT, d, h);
    n_tests++;
    if (d[5] !== 1'b0 || d[3] !== 1'b0) begin n_fail++; $display("FAIL rx_framing: got 0x%08h, expected bits5,3 clear", d); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d; logic h; int e, e0, bad;
    store(BASE, 32'h33, e0);
    store(BASE, 32'h5A, e);
    store(BASE, 32'hC3, e);
    // data bit 3 occupies [start + 4*DIV, start + 5*DIV); start = e0 + 2
    while (cyc < e0 + 2 + 4 * DIV + DIV / 2) @(negedge clk);
    n_tests++;
    if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: got %b, expected 0", uart_tx); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_async_tx: got %b, expected 1", uart_tx); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL mid_no_frames: got %0d low cycles, expected 0", bad); end
    read(STAT, d, h);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL mid_status: got 0x%08h, expected 0x00000002", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_decode();
    test_random();
`ifdef UART_MMIO_RX_EN
    test_rx();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
